// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param.
//   master (receiver): drives rx_data, rx_valid, frame_err, parity_err,
//                      overrun_err, break_det; samples rx_ready
//   slave  (consumer): samples the word and flags; drives rx_ready
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;
    logic                 break_det;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun_err, break_det,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun_err, break_det,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready holding register.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   rx     asynchronous serial input, idle high
//   bus    uart_rx_param_if.master: rx_data/rx_valid/rx_ready handshake plus
//          frame_err, parity_err (qualified by rx_valid), overrun_err and
//          break_det one-cycle pulses
// Optional feature macro: UART_RX_BREAK_DET_EN enables line-break detection;
// when undefined break_det is tied 0 and an all-zero frame is delivered.
module uart_rx_param #(
    parameter int unsigned CLOCK_RATE = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    uart_rx_param_if.master bus
);
    localparam int unsigned DIV    = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF   = OVERSAMPLE / 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_WAIT   = 3'd6;

    // Input path: 2-FF synchroniser then 3-sample majority filter
    logic       sync1, sync2, rxf;
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 2'b11;
            rxf   <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};
            rxf   <= (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
        end
    end

    logic [2:0]           state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 ovr_q, ovr_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                 zero_q, zero_d;
    logic                 brk_q, brk_d;
`endif

    logic tick_c, half_c, mid_c, counting_c, parity_bad_c;

    assign tick_c     = (div_cnt_q == DIV_W'(DIV - 1));
    assign half_c     = tick_c && (tick_cnt_q == TICK_W'(HALF - 1));
    assign mid_c      = tick_c && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
    assign counting_c = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
    // par_q is the XOR of data and parity bit: odd mode wants 1, even wants 0
    assign parity_bad_c = (PARITY == 1) ? ~par_q :
                          (PARITY == 2) ?  par_q : 1'b0;

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = '0;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        valid_d    = valid_q;
        fe_d       = fe_q;
        pe_d       = pe_q;
        ovr_d      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        zero_d     = zero_q;
        brk_d      = 1'b0;
`endif

        // Consumer handshake; DONE may reload in the same cycle
        if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end

        // Baud tick divider runs only while a frame is in progress
        if (counting_c) begin
            div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rxf) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_c) begin
                    tick_cnt_d = half_c ? '0 : tick_cnt_q + TICK_W'(1);
                end
                if (half_c) begin
                    if (rxf) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        par_d      = 1'b0;
                        ferr_acc_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        zero_d     = 1'b1;
`endif
                    end
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    tick_cnt_d = mid_c ? '0 : tick_cnt_q + TICK_W'(1);
                end
                if (mid_c) begin
                    shift_d = {rxf, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ rxf;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d  = zero_q & ~rxf;
`endif
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick_c) begin
                    tick_cnt_d = mid_c ? '0 : tick_cnt_q + TICK_W'(1);
                end
                if (mid_c) begin
                    par_d   = par_q ^ rxf;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d  = zero_q & ~rxf;
`endif
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    tick_cnt_d = mid_c ? '0 : tick_cnt_q + TICK_W'(1);
                end
                if (mid_c) begin
                    if (!rxf) begin
                        ferr_acc_d = 1'b1;
                    end
`ifdef UART_RX_BREAK_DET_EN
                    // Only the first stop bit takes part in break detection
                    if (bit_cnt_q == '0) begin
                        zero_d = zero_q & ~rxf;
                    end
`endif
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = ferr_acc_q ? S_WAIT : S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                if (zero_q) begin
                    brk_d   = 1'b1;
                    state_d = S_WAIT;
                end else
`endif
                begin
                    if (!valid_q || bus.rx_ready) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        fe_d    = ferr_acc_q;
                        pe_d    = parity_bad_c;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Held-low line after a bad stop must not retrigger a frame
                if (rxf) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_q     <= 1'b0;
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
            zero_q     <= zero_d;
            brk_q      <= brk_d;
`endif
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.frame_err   = fe_q;
    assign bus.parity_err  = pe_q;
    assign bus.overrun_err = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
    assign bus.break_det   = brk_q;
`else
    assign bus.break_det   = 1'b0;
`endif

endmodule
